// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - CP0 operation encodings, register indices and bit positions
package cp0_unit_pkg;

  typedef enum logic [1:0] {
    EXE_CP0_NONE  = 2'd0,
    EXE_CP0_STORE = 2'd1,
    EXE_CP0_ERET  = 2'd2,
    EXE_CP0_RSVD  = 2'd3
  } cp0_oper_e;

  typedef enum logic {
    CP0_RUN     = 1'b0,
    CP0_HANDLER = 1'b1
  } cp0_state_e;

  localparam logic [4:0] CP0_IDX_COUNT   = 5'd9;
  localparam logic [4:0] CP0_IDX_COMPARE = 5'd11;
  localparam logic [4:0] CP0_IDX_STATUS  = 5'd12;
  localparam logic [4:0] CP0_IDX_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_IDX_EPC     = 5'd14;

  localparam int STATUS_IE      = 0;
  localparam int STATUS_EXL     = 1;
  localparam int CAUSE_IP_EXT   = 8;
  localparam int CAUSE_IP_TIMER = 15;

  localparam logic [31:0] CP0_EXC_HANDLER_DEFAULT = 32'h0000_0008;

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline-to-CP0 operation and redirect bundle
interface cp0_unit_if;

  logic        en;
  logic [1:0]  oper;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [31:0] ret_addr;
  logic        jump_en;
  logic [31:0] jump_addr;

  // Pipeline side: issues operations, consumes read data and redirects
  modport master (
    output en, oper, addr_w, data_w, addr_r, ret_addr,
    input  data_r, jump_en, jump_addr
  );

  // CP0 side
  modport slave (
    input  en, oper, addr_w, data_w, addr_r, ret_addr,
    output data_r, jump_en, jump_addr
  );

endinterface

// File: rtl/cp0_unit_irq_sync.sv
// rtl/cp0_unit_irq_sync.sv - two-flop synchronizer with rising-edge detect for the external interrupt
module irq_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic irq_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the asynchronous level and keep one stage of history for edge detect
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 responder: STATUS/CAUSE/EPC, interrupt entry and ERET redirect; CP0_COUNT_EN adds COUNT/COMPARE
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] EXC_HANDLER = CP0_EXC_HANDLER_DEFAULT
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     ir_in_i,
  cp0_unit_if.slave cp0
);

  cp0_state_e  state_q;
  logic        ie_q;
  logic [31:0] epc_q;
  logic        ip_ext_q;
  logic        ip_timer;
  logic        jump_en_q;
  logic [31:0] jump_addr_q;

  logic        exl;
  logic        ir_rise;
  logic        is_store;
  logic        is_eret;
  logic        take;
  logic        wr_status;
  logic        wr_epc;
  logic [31:0] rdata;

  irq_sync u_irq_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .irq_i  (ir_in_i),
    .rise_o (ir_rise)
  );

  assign exl = (state_q == CP0_HANDLER);

  // Decode the operation in EXE; ERET is blocked while a redirect is still outstanding
  always_comb begin
    is_store  = cp0.en && (cp0.oper == EXE_CP0_STORE);
    is_eret   = cp0.en && (cp0.oper == EXE_CP0_ERET) && !jump_en_q;
    take      = cp0.en && (ip_ext_q || ip_timer) && ie_q && !exl && !jump_en_q &&
                (cp0.oper != EXE_CP0_ERET);
    wr_status = is_store && (cp0.addr_w == CP0_IDX_STATUS);
    wr_epc    = is_store && (cp0.addr_w == CP0_IDX_EPC);
  end

  // External pending bit: a fresh edge wins over the clear from a simultaneous entry
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ip_ext_q <= 1'b0;
    end else if (ir_rise) begin
      ip_ext_q <= 1'b1;
    end else if (take) begin
      ip_ext_q <= 1'b0;
    end
  end

  // EXL state machine with architectural registers and the registered redirect
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= CP0_RUN;
      ie_q        <= 1'b0;
      epc_q       <= '0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
    end else if (cp0.en) begin
      jump_en_q <= take | is_eret;
      if (wr_status) ie_q <= cp0.data_w[STATUS_IE];
      if (wr_epc) epc_q <= cp0.data_w;
      case (state_q)
        CP0_RUN: begin
          if (take) begin
            // Entry capture is assigned last so it overrides an MTC0 to EPC
            state_q     <= CP0_HANDLER;
            epc_q       <= cp0.ret_addr;
            jump_addr_q <= EXC_HANDLER;
          end else if (is_eret) begin
            jump_addr_q <= epc_q;
          end else if (wr_status && cp0.data_w[STATUS_EXL]) begin
            state_q <= CP0_HANDLER;
          end
        end
        CP0_HANDLER: begin
          if (is_eret) begin
            state_q     <= CP0_RUN;
            jump_addr_q <= epc_q;
          end else if (wr_status && !cp0.data_w[STATUS_EXL]) begin
            state_q <= CP0_RUN;
          end
        end
        default: state_q <= CP0_RUN;
      endcase
    end
  end

`ifdef CP0_COUNT_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ip_timer_q;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = is_store && (cp0.addr_w == CP0_IDX_COUNT);
  assign wr_compare = is_store && (cp0.addr_w == CP0_IDX_COMPARE);

  // Free-running counter, compare register and timer pending bit; runs regardless of en
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      ip_timer_q <= 1'b0;
    end else begin
      count_q <= wr_count ? cp0.data_w : count_q + 32'd1;
      if (wr_compare) begin
        compare_q  <= cp0.data_w;
        ip_timer_q <= 1'b0;
      end else if (count_q == compare_q) begin
        ip_timer_q <= 1'b1;
      end
    end
  end

  assign ip_timer = ip_timer_q;
`else
  assign ip_timer = 1'b0;
`endif

  // MFC0 read mux straight from the current register values
  always_comb begin
    rdata = '0;
    case (cp0.addr_r)
      CP0_IDX_STATUS: begin
        rdata[STATUS_IE]  = ie_q;
        rdata[STATUS_EXL] = exl;
      end
      CP0_IDX_CAUSE: begin
        rdata[CAUSE_IP_EXT]   = ip_ext_q;
        rdata[CAUSE_IP_TIMER] = ip_timer;
      end
      CP0_IDX_EPC: rdata = epc_q;
`ifdef CP0_COUNT_EN
      CP0_IDX_COUNT:   rdata = count_q;
      CP0_IDX_COMPARE: rdata = compare_q;
`endif
      default: rdata = '0;
    endcase
  end

  assign cp0.data_r    = rdata;
  assign cp0.jump_en   = jump_en_q;
  assign cp0.jump_addr = jump_addr_q;

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 responder for the 5-stage MIPS pipeline: executes the CP0 operations decoded by the pipeline controller (MTC0, MFC0 read, ERET), owns STATUS/CAUSE/EPC, and accepts an external interrupt. Raises a one-pulse redirect (`jump_en` + `jump_addr`) toward the PC select logic, either on interrupt entry or on ERET. Sits beside the EXE stage and consumes the controller's `oper` field.

## Interface
- `EXC_HANDLER`, default 32'h0000_0008: interrupt handler entry address.
- `clk`  in  1  main clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  EXE stage enable; 0 freezes architectural state.
- `oper`  in  2  CP0 operation: NONE=0, STORE (MTC0)=1, ERET=2, 3 reserved (treated as NONE).
- `addr_w`  in  5  CP0 register index for MTC0.
- `data_w`  in  32  MTC0 write data (forwarded rt value).
- `addr_r`  in  5  CP0 register index for MFC0.
- `data_r`  out  32  MFC0 read data, combinational from current registers.
- `ir_in`  in  1  external interrupt request, level, asynchronous to `clk`.
- `ret_addr`  in  32  resume PC of the instruction in EXE; captured into EPC on entry.
- `jump_en`  out  1  redirect request (epc_ctrl), registered.
- `jump_addr`  out  32  redirect target, registered.

## Operation
- Registers: STATUS (idx 12): bit0 IE, bit1 EXL, other bits read 0. CAUSE (idx 13): bit8 IP_EXT, bit15 IP_TIMER, others 0. EPC (idx 14): 32 bits. Other indices read 0, writes ignored.
- MTC0 (`oper`=STORE, `en`=1): writes STATUS[1:0] or EPC; CAUSE is read-only.
- `ir_in` passes a 2-flop synchronizer; rising edge of the synchronized level sets IP_EXT. IP_EXT clears only on interrupt entry.
- Take condition (evaluated on pre-edge values): (IP_EXT | IP_TIMER) & IE & ~EXL & ~`jump_en` & `en` & `oper`!=ERET.
- Entry: EPC<=`ret_addr`, EXL<=1, IP_EXT<=0, `jump_addr`<=EXC_HANDLER, `jump_en`<=1.
- ERET (`en`=1, ~`jump_en`): EXL<=0, `jump_addr`<=EPC, `jump_en`<=1.
- Two-state FSM on EXL: RUN (EXL=0) -> HANDLER on entry; HANDLER -> RUN on ERET or MTC0 clearing EXL.
- `jump_en` is a one-cycle pulse when `en`=1; it holds its value while `en`=0 and clears on the first `en`=1 edge.
- Boundaries:
  - ERET and take condition in the same cycle: ERET wins. Interrupt stays pending and is taken at the first eligible cycle after the ERET pulse.
  - MTC0 to STATUS on the entry edge: IE takes the written value, EXL is forced to 1.
  - MTC0 to EPC on the entry edge: entry capture wins.
  - ERET while EXL=0: still redirects to EPC.
  - `en`=0: synchronizer and IP_EXT capture keep running; everything else holds.

## Timing
- Reset values: STATUS=0, CAUSE=0, EPC=0, `jump_en`=0, `jump_addr`=0, sync flops 0; COUNT=0 and COMPARE=32'hFFFF_FFFF when `CP0_COUNT_EN` is defined. `data_r` reflects reset registers.
- `ir_in` rise to IP_EXT set: 3 edges.
- IP_EXT set to `jump_en` high: 1 edge, if eligible.
- ERET in EXE to `jump_en` high: 1 edge.
- MTC0 is visible to MFC0 `data_r` the cycle after the write edge; there is no internal bypass.
- Reset assertion mid-pulse clears `jump_en` immediately (async).

## Configuration
- `CP0_COUNT_EN` defined: adds COUNT (idx 9) and COMPARE (idx 11).
  - COUNT increments every clock, wraps at 2^32. It advances even when `en`=0.
  - When COUNT==COMPARE, IP_TIMER is set.
  - MTC0 to COMPARE clears IP_TIMER. MTC0 to COUNT loads it; that write wins over the increment.
- Undefined: idx 9/11 read 0, writes ignored, IP_TIMER constant 0.

## Structure
- Shared define header (mips_define.vh): `oper` encodings (EXE_CP0_NONE/STORE/ERET), CP0 register indices, STATUS/CAUSE bit positions. `EXC_HANDLER` default also lives there.
- One sub-module, `irq_sync`: 2-flop synchronizer plus rising-edge detect. Uses the same `clk` and async active-low `rst`.

## Test plan
- Reset, then read idx 12/13/14 -> all 0; `jump_en`=0.
- MTC0 STATUS=1, raise `ir_in` with `ret_addr`=32'h40 -> `jump_en` pulse, `jump_addr`=32'h8, EPC=32'h40, STATUS=2'b11, CAUSE bit8=0.
- Then ERET -> 1 edge later `jump_en` pulse with `jump_addr`=32'h40, EXL=0. A second `ir_in` edge during HANDLER is held pending and taken right after the ERET pulse.
- ERET and pending interrupt in the same cycle -> first pulse targets EPC; interrupt entry follows on a later cycle.
- `en`=0 for 3 cycles during a `jump_en` pulse -> `jump_en` stays 1; it clears after `en` returns to 1. MTC0 is ignored while `en`=0.
- With `CP0_COUNT_EN`: COMPARE=10, IE=1 -> entry when COUNT reaches 10. MTC0 COMPARE=50 clears CAUSE bit15.
